// File: rtl/reg_wb_pkg.sv
// Shared types for the register write-back arbiter.
package reg_wb_pkg;

   localparam int unsigned WB_DATA_W   = 32;
   localparam int unsigned WB_NUM_REGS = 4;
   localparam int unsigned WB_IDX_W    = $clog2(WB_NUM_REGS);

   typedef struct packed {
      logic [WB_IDX_W-1:0]  addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for one write-back source; exposes all slots in
// head-relative order so the owner can scan pending destinations.
module wb_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 8,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [Width-1:0]             wdata,
   output logic [Width-1:0]             head_c,
   output logic                         full_c,
   output logic                         empty_c,
   output logic [CntW-1:0]              count,
   output logic [Depth-1:0][Width-1:0]  slots_c
);

   logic [Depth-1:0][Width-1:0] mem_q;
   logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]             count_q, count_d;
   logic                        push_ok, pop_ok;

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == CntW'(Depth));
   assign push_ok = push && !full_c;
   assign pop_ok  = pop && !empty_c;
   assign head_c  = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers wrap naturally since Depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      slots_c = '0;
      for (int unsigned i = 0; i < Depth; i++) begin
         slots_c[i] = mem_q[rd_ptr_q + PtrW'(i)];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter in front of the register file write port,
// with a registered pending-write mask for operand hazard checks.
module reg_wb_arbiter
   import reg_wb_pkg::*;
#(
   parameter int unsigned DataWidth  = WB_DATA_W,
   parameter int unsigned NumRegs    = WB_NUM_REGS,
   parameter int unsigned IndexWidth = $clog2(NumRegs),
   parameter int unsigned FifoDepth  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  aValid,
   output logic                  aReady,
   input  logic [IndexWidth-1:0] aAddr,
   input  logic [DataWidth-1:0]  aData,
   input  logic                  bValid,
   output logic                  bReady,
   input  logic [IndexWidth-1:0] bAddr,
   input  logic [DataWidth-1:0]  bData,
   output logic                  writeEn,
   output logic [IndexWidth-1:0] writeAddr,
   output logic [DataWidth-1:0]  writeData,
   output logic [NumRegs-1:0]    pendingMask
);

   localparam int unsigned ReqW = IndexWidth + DataWidth;
   localparam int unsigned CntW = $clog2(FifoDepth + 1);

   logic [ReqW-1:0]                 a_head, b_head;
   logic                            a_full, b_full, a_empty, b_empty;
   logic [CntW-1:0]                 a_count, b_count;
   logic [FifoDepth-1:0][ReqW-1:0]  a_slots, b_slots;
   logic                            grant_a_c, grant_b_c;

   wb_src_e                         last_grant_q, last_grant_d;
   logic                            write_en_q, write_en_d;
   logic [IndexWidth-1:0]           write_addr_q, write_addr_d;
   logic [DataWidth-1:0]            write_data_q, write_data_d;
   logic [NumRegs-1:0]              pending_q, pending_d;

   assign aReady = rst && !a_full;
   assign bReady = rst && !b_full;

   wb_fifo #(.Depth(FifoDepth), .Width(ReqW)) u_fifo_a (
      .clk     (clk),
      .rst_n   (rst),
      .push    (aValid),
      .pop     (grant_a_c),
      .wdata   ({aAddr, aData}),
      .head_c  (a_head),
      .full_c  (a_full),
      .empty_c (a_empty),
      .count   (a_count),
      .slots_c (a_slots)
   );

   wb_fifo #(.Depth(FifoDepth), .Width(ReqW)) u_fifo_b (
      .clk     (clk),
      .rst_n   (rst),
      .push    (bValid),
      .pop     (grant_b_c),
      .wdata   ({bAddr, bData}),
      .head_c  (b_head),
      .full_c  (b_full),
      .empty_c (b_empty),
      .count   (b_count),
      .slots_c (b_slots)
   );

   // Grant decision and next lastGrant; on a tie the source not granted last wins.
   always_comb begin
      grant_a_c    = 1'b0;
      grant_b_c    = 1'b0;
      last_grant_d = last_grant_q;
      if (!a_empty && !b_empty) begin
         if (last_grant_q == SRC_B) grant_a_c = 1'b1;
         else                       grant_b_c = 1'b1;
      end else if (!a_empty) begin
         grant_a_c = 1'b1;
      end else if (!b_empty) begin
         grant_b_c = 1'b1;
      end
      if (grant_a_c)      last_grant_d = SRC_A;
      else if (grant_b_c) last_grant_d = SRC_B;
   end

   // Output stage: address/data hold when nothing is granted.
   always_comb begin
      write_en_d   = grant_a_c || grant_b_c;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      if (grant_a_c) begin
         write_addr_d = a_head[ReqW-1:DataWidth];
         write_data_d = a_head[DataWidth-1:0];
      end else if (grant_b_c) begin
         write_addr_d = b_head[ReqW-1:DataWidth];
         write_data_d = b_head[DataWidth-1:0];
      end
   end

   always_comb begin
      pending_d = '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
         if (CntW'(i) < a_count)
            pending_d = pending_d | (NumRegs'(1) << a_slots[i][ReqW-1:DataWidth]);
         if (CntW'(i) < b_count)
            pending_d = pending_d | (NumRegs'(1) << b_slots[i][ReqW-1:DataWidth]);
      end
      if (write_en_q) pending_d = pending_d | (NumRegs'(1) << write_addr_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= SRC_B;
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         pending_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         pending_q    <= pending_d;
      end
   end

   assign writeEn     = write_en_q;
   assign writeAddr   = write_addr_q;
   assign writeData   = write_data_q;
   assign pendingMask = pending_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with hand-traced expected commits.
module tb_reg_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        aValid, bValid;
   logic        aReady, bReady;
   logic [1:0]  aAddr, bAddr;
   logic [31:0] aData, bData;
   logic        writeEn;
   logic [1:0]  writeAddr;
   logic [31:0] writeData;
   logic [3:0]  pendingMask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_wb_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .aValid      (aValid),
      .aReady      (aReady),
      .aAddr       (aAddr),
      .aData       (aData),
      .bValid      (bValid),
      .bReady      (bReady),
      .bAddr       (bAddr),
      .bData       (bData),
      .writeEn     (writeEn),
      .writeAddr   (writeAddr),
      .writeData   (writeData),
      .pendingMask (pendingMask)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input string tag, input logic [1:0] addr, input logic [31:0] data);
      check({tag, "_we"}, 64'(writeEn), 64'd1);
      check({tag, "_addr"}, 64'(writeAddr), 64'(addr));
      check({tag, "_data"}, 64'(writeData), 64'(data));
   endtask

   task automatic do_reset();
      rst    = 1'b0;
      aValid = 1'b0;
      bValid = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      // Reset with aValid held high.
      rst = 1'b0; aValid = 1'b1; aAddr = 2'd2; aData = 32'hDEAD;
      bValid = 1'b0; bAddr = 2'd0; bData = 32'h0;
      step(); step();
      check("rst_aReady", 64'(aReady), 64'd0);
      check("rst_bReady", 64'(bReady), 64'd0);
      check("rst_we", 64'(writeEn), 64'd0);
      check("rst_pm", 64'(pendingMask), 64'd0);
      check("rst_addr", 64'(writeAddr), 64'd0);
      check("rst_data", 64'(writeData), 64'd0);
      aValid = 1'b0;
      rst = 1'b1;
      #1;
      check("rel_aReady", 64'(aReady), 64'd1);
      check("rel_bReady", 64'(bReady), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_we", 64'(writeEn), 64'd0);
      end

      // Single push from A.
      aValid = 1'b1; aAddr = 2'd2; aData = 32'h0A0A;
      step();
      aValid = 1'b0;
      check("single_acc_we", 64'(writeEn), 64'd0);
      check("single_acc_pm", 64'(pendingMask), 64'd0);
      step();
      commit("single", 2'd2, 32'h0A0A);
      check("single_pm1", 64'(pendingMask), 64'h4);
      step();
      check("single_we_off", 64'(writeEn), 64'd0);
      check("single_pm2", 64'(pendingMask), 64'h4);
      check("single_hold_addr", 64'(writeAddr), 64'd2);
      check("single_hold_data", 64'(writeData), 64'h0A0A);
      step();
      check("single_pm_clr", 64'(pendingMask), 64'd0);

      // Saturation from both sources.
      do_reset();
      aValid = 1'b1; aAddr = 2'd1; aData = 32'h0505;
      bValid = 1'b1; bAddr = 2'd3; bData = 32'h3333;
      step();
      check("sat_e1_we", 64'(writeEn), 64'd0);
      step();
      commit("sat_e2", 2'd1, 32'h0505);
      check("sat_e2_aReady", 64'(aReady), 64'd1);
      check("sat_e2_bReady", 64'(bReady), 64'd0);
      step();
      commit("sat_e3", 2'd3, 32'h3333);
      check("sat_e3_aReady", 64'(aReady), 64'd0);
      check("sat_e3_bReady", 64'(bReady), 64'd1);
      step();
      commit("sat_e4", 2'd1, 32'h0505);
      step();
      commit("sat_e5", 2'd3, 32'h3333);
      aValid = 1'b0; bValid = 1'b0;
      step();
      commit("sat_e6", 2'd1, 32'h0505);
      step();
      commit("sat_e7", 2'd3, 32'h3333);
      step();
      commit("sat_e8", 2'd1, 32'h0505);
      step();
      check("sat_e9_we", 64'(writeEn), 64'd0);
      step();
      check("sat_e10_pm", 64'(pendingMask), 64'd0);

      // A fills while B takes alternate grants; order kept across wrap.
      do_reset();
      aValid = 1'b1; aAddr = 2'd2; aData = 32'hA000;
      bValid = 1'b1; bAddr = 2'd0; bData = 32'hB0B0;
      step();
      aData = 32'hA001;
      check("wrap_e1_we", 64'(writeEn), 64'd0);
      step();
      commit("wrap_e2", 2'd2, 32'hA000);
      check("wrap_e2_aReady", 64'(aReady), 64'd1);
      aData = 32'hA002;
      step();
      commit("wrap_e3", 2'd0, 32'hB0B0);
      check("wrap_e3_aReady", 64'(aReady), 64'd0);
      aData = 32'hA003;
      step();
      commit("wrap_e4", 2'd2, 32'hA001);
      check("wrap_e4_aReady", 64'(aReady), 64'd1);
      step();
      commit("wrap_e5", 2'd0, 32'hB0B0);
      aValid = 1'b0; bValid = 1'b0;
      step();
      commit("wrap_e6", 2'd2, 32'hA002);
      step();
      commit("wrap_e7", 2'd0, 32'hB0B0);
      step();
      commit("wrap_e8", 2'd2, 32'hA003);
      step();
      check("wrap_e9_we", 64'(writeEn), 64'd0);

      // Same register written by both sources on the same edge.
      do_reset();
      aValid = 1'b1; aAddr = 2'd1; aData = 32'h1111;
      bValid = 1'b1; bAddr = 2'd1; bData = 32'h2222;
      step();
      aValid = 1'b0; bValid = 1'b0;
      check("same_e1_we", 64'(writeEn), 64'd0);
      check("same_e1_pm", 64'(pendingMask), 64'd0);
      step();
      commit("same_e2", 2'd1, 32'h1111);
      check("same_e2_pm", 64'(pendingMask), 64'h2);
      step();
      commit("same_e3", 2'd1, 32'h2222);
      check("same_e3_pm", 64'(pendingMask), 64'h2);
      step();
      check("same_e4_we", 64'(writeEn), 64'd0);
      check("same_e4_pm", 64'(pendingMask), 64'h2);
      step();
      check("same_e5_pm", 64'(pendingMask), 64'd0);

      // Reset with three entries buffered drops them all.
      do_reset();
      aValid = 1'b1; aAddr = 2'd1; aData = 32'h0505;
      bValid = 1'b1; bAddr = 2'd3; bData = 32'h3333;
      step(); step(); step();
      aValid = 1'b0; bValid = 1'b0;
      commit("mid_pre", 2'd3, 32'h3333);
      rst = 1'b0;
      #1;
      check("mid_async_we", 64'(writeEn), 64'd0);
      check("mid_async_pm", 64'(pendingMask), 64'd0);
      check("mid_async_aReady", 64'(aReady), 64'd0);
      check("mid_async_addr", 64'(writeAddr), 64'd0);
      step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("mid_post_we", 64'(writeEn), 64'd0);
         check("mid_post_pm", 64'(pendingMask), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
